quadrature_decoder: RTL and testbench
=====================================

# quadrature_decoder

Converts the raw A/B outputs of the pong paddle rotary encoder into the one-cycle step strobe, direction and speed signals consumed by the paddle position counter. Each input is synchronised and deglitched, then a transition tracker turns every valid Gray-code step into a `COUNT_ENABLE` pulse. An illegal double transition raises `ERROR`, and a windowed step count feeds `SPEED`. One instance sits between each encoder's GPIO pins and its paddle counter.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per input (≥2).
- `FILTER_CYCLES`, 16: consecutive cycles a changed input must persist before acceptance (≥1).
- `WINDOW_CYCLES`, 500000: length of the speed measurement window in clocks (≥2).
- `CLOCK  in  1`: system clock; all logic on rising edge.
- `RESET  in  1`: asynchronous, active-high; clock `CLOCK`.
- `ENC_A  in  1`: raw encoder channel A, asynchronous to `CLOCK`.
- `ENC_B  in  1`: raw encoder channel B, asynchronous to `CLOCK`.
- `COUNT_ENABLE  out  1`: one-cycle pulse per accepted step.
- `DIRECTION  out  1`: 1 = clockwise/up, 0 = counter-clockwise/down; valid whenever `COUNT_ENABLE` = 1, holds the last step direction otherwise.
- `SPEED  out  4`: steps counted in the last completed window, saturated at 15.
- `ERROR  out  1`: one-cycle pulse on an illegal transition (both channels changed in the same cycle).

## Operation
- Synchroniser: `SYNC_STAGES` flops per channel, reset to 0.
- Filter, per channel: a filtered value `filt` (reset 0) and a mismatch counter (reset 0).
  - Sync output ≠ `filt`: counter increments. On the `FILTER_CYCLES`-th consecutive mismatch cycle, `filt` takes the sync value and the counter clears.
  - Sync output = `filt`: counter clears.
  - Pulses shorter than `FILTER_CYCLES` cycles are never passed.
- Tracker FSM, states SETTLE and TRACK:
  - SETTLE (reset state): a settle counter runs `SYNC_STAGES + FILTER_CYCLES + 1` cycles. `prev` = {filtA, filtB} is loaded on the last cycle, then the FSM enters TRACK. No `COUNT_ENABLE`, `ERROR` or window activity in SETTLE. The encoder's resting position after reset therefore never produces a step.
  - TRACK: compare `cur` = {filtA, filtB} with `prev` every cycle, then set `prev` <= `cur`.
    - Clockwise sequence 00→01→11→10→00: `COUNT_ENABLE`=1, `DIRECTION`=1.
    - Reverse sequence 00→10→11→01→00: `COUNT_ENABLE`=1, `DIRECTION`=0.
    - Both bits differ: `ERROR`=1, no count, `DIRECTION` unchanged.
    - No change: no pulse.
  - The FSM never leaves TRACK except through `RESET`.
- Speed: a window counter runs 0..`WINDOW_CYCLES`-1 in TRACK, alongside a 4-bit saturating step accumulator.
  - On the last window cycle, `SPEED` <= accumulator and the accumulator clears.
  - A step in that same cycle is counted in the closing window.
  - The accumulator saturates at 15 and never wraps.
- Reset values: `COUNT_ENABLE`=0, `DIRECTION`=0, `SPEED`=0, `ERROR`=0. All counters are 0 and the FSM is in SETTLE.
- `RESET` mid-operation: all state clears immediately and asynchronously, and settle restarts after deassertion. A step in flight is dropped.
- All outputs are registered.

## Timing
- Latency: a clean input edge first sampled at clock edge k gives `COUNT_ENABLE` high in the cycle after edge k + `SYNC_STAGES` + `FILTER_CYCLES`. This is a fixed pipeline with no jitter beyond ±1 cycle of synchroniser uncertainty.
- `COUNT_ENABLE` and `ERROR` are exactly one cycle wide, mutually exclusive, and at most one per cycle.
- Minimum step spacing: one step per `FILTER_CYCLES` cycles per channel. Faster input is filtered out, not miscounted.
- `SPEED` updates once per `WINDOW_CYCLES` cycles, registered one cycle after the window's last cycle. The first update comes `WINDOW_CYCLES` cycles after entering TRACK.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `FILTER_CYCLES`=4, `WINDOW_CYCLES`=100.
- Reset with A=B=1 held, release, wait 50 cycles -> no `COUNT_ENABLE`, no `ERROR`; `SPEED`=0.
- Clockwise sequence 00→01→11→10→00, 20 cycles per state -> exactly 4 `COUNT_ENABLE` pulses with `DIRECTION`=1, each 7 cycles after its input edge ±1.
- Reverse sequence 00→10→11→01→00 -> 4 pulses with `DIRECTION`=0; `DIRECTION` stays 0 afterwards.
- 3-cycle glitch on A, then a 4-cycle pulse on A -> glitch ignored; the 4-cycle pulse gives +1 then −1.
- A and B toggled in the same cycle from 00 to 11, held 20 cycles -> one `ERROR` pulse, no `COUNT_ENABLE`, `DIRECTION` unchanged.
- Speed and reset:
  - 20 clockwise steps inside one window -> `SPEED`=15 (saturated) at window end; an idle next window gives `SPEED`=0.
  - `RESET` asserted mid-step -> all outputs 0 next cycle, then settle restarts.

Source files
------------

// File: rtl/quadrature_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// quadrature_decoder
//
// Turns the raw A/B outputs of a rotary encoder into step strobes for the
// paddle position counter. Each channel is synchronised into the CLOCK domain
// and deglitched by a persistence filter. A small tracker FSM then follows the
// Gray-code sequence on the filtered pair and emits one COUNT_ENABLE pulse
// per valid step. A simultaneous change on both channels is reported on
// ERROR. The number of steps in each fixed-length window is published
// on SPEED.
//
// Parameters
//   SYNC_STAGES    synchroniser flops per channel (>= 2)
//   FILTER_CYCLES  cycles a changed input must persist before acceptance (>= 1)
//   WINDOW_CYCLES  speed measurement window length in clocks (>= 2)
//
// Ports
//   CLOCK         in   system clock, rising edge
//   RESET         in   asynchronous, active-high reset
//   ENC_A         in   raw encoder channel A (asynchronous)
//   ENC_B         in   raw encoder channel B (asynchronous)
//   COUNT_ENABLE  out  one-cycle pulse per accepted step
//   DIRECTION     out  1 = clockwise/up, 0 = counter-clockwise/down; holds
//                      the direction of the last step
//   SPEED         out  steps in the last completed window, saturated at 15
//   ERROR         out  one-cycle pulse when both channels changed together
// -----------------------------------------------------------------------------
module quadrature_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 16,
   parameter int WINDOW_CYCLES = 500000
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       ENC_A,
   input  logic       ENC_B,
   output logic       COUNT_ENABLE,
   output logic       DIRECTION,
   output logic [3:0] SPEED,
   output logic       ERROR
);

   // Settling covers the synchroniser plus one full filter period, so the
   // filtered pair already reflects the resting encoder position when it is
   // captured as the first "previous" value.
   localparam int SETTLE_LEN = SYNC_STAGES + FILTER_CYCLES + 1;
   localparam int SETTLE_W   = $clog2(SETTLE_LEN);
   localparam int FILT_W     = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam int WIN_W      = $clog2(WINDOW_CYCLES);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_LEN - 1);
   localparam logic [FILT_W-1:0]   FILT_LAST   = FILT_W'(FILTER_CYCLES - 1);
   localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);

   // Bit 1 carries channel A, bit 0 channel B, matching the {A, B} notation
   // used for the Gray-code sequence below.
   logic [1:0] raw;
   logic [1:0] filt;

   assign raw = {ENC_A, ENC_B};

   // --------------------------------------------------------------------------
   // Per-channel synchroniser and persistence filter
   // --------------------------------------------------------------------------
   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   filt_q;
      logic [FILT_W-1:0]      mis_cnt_q;
      logic                   sync_out;
      logic                   mismatch;

      assign sync_out = sync_q[SYNC_STAGES-1];
      assign mismatch = (sync_out != filt_q);

      always_ff @(posedge CLOCK or posedge RESET) begin
         if (RESET) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
         end
      end

      // The counter holds the number of mismatch cycles already seen; the
      // FILTER_CYCLES-th consecutive mismatch is the one that finds it at
      // FILTER_CYCLES-1, so the new value is accepted on that same cycle.
      always_ff @(posedge CLOCK or posedge RESET) begin
         if (RESET) begin
            filt_q    <= 1'b0;
            mis_cnt_q <= '0;
         end else if (mismatch) begin
            if (mis_cnt_q == FILT_LAST) begin
               filt_q    <= sync_out;
               mis_cnt_q <= '0;
            end else begin
               mis_cnt_q <= mis_cnt_q + FILT_W'(1);
            end
         end else begin
            mis_cnt_q <= '0;
         end
      end

      assign filt[ch] = filt_q;
   end

   // --------------------------------------------------------------------------
   // Transition decode
   // --------------------------------------------------------------------------
   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_TRACK  = 1'b1
   } state_t;

   state_t              state_q;
   logic [SETTLE_W-1:0] settle_cnt_q;
   logic [1:0]          prev_q;
   logic [WIN_W-1:0]    win_cnt_q;
   logic [3:0]          acc_q;
   logic [3:0]          acc_d;
   logic                count_enable_q;
   logic                direction_q;
   logic                error_q;
   logic [3:0]          speed_q;

   logic [1:0]          cw_next;
   logic [1:0]          ccw_next;
   logic                step_cw;
   logic                step_ccw;
   logic                step;
   logic                illegal;
   logic                win_last;

   // Clockwise order is 00 -> 01 -> 11 -> 10 -> 00; the reverse order is the
   // same ring walked the other way. Anything that is neither a neighbour nor
   // the same code is the opposite corner, i.e. both channels moved.
   always_comb begin
      cw_next  = 2'b00;
      ccw_next = 2'b00;
      case (prev_q)
         2'b00: begin
            cw_next  = 2'b01;
            ccw_next = 2'b10;
         end
         2'b01: begin
            cw_next  = 2'b11;
            ccw_next = 2'b00;
         end
         2'b11: begin
            cw_next  = 2'b10;
            ccw_next = 2'b01;
         end
         default: begin
            cw_next  = 2'b00;
            ccw_next = 2'b11;
         end
      endcase

      step_cw  = (filt == cw_next);
      step_ccw = (filt == ccw_next);
      step     = step_cw | step_ccw;
      illegal  = (filt == ~prev_q);
      win_last = (win_cnt_q == WIN_LAST);

      // Saturating step accumulator; a step on the closing cycle still
      // lands in the window being closed.
      acc_d = acc_q;
      if (step && (acc_q != 4'hF)) begin
         acc_d = acc_q + 4'd1;
      end
   end

   // --------------------------------------------------------------------------
   // Tracker FSM with registered outputs and speed window
   // --------------------------------------------------------------------------
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q        <= ST_SETTLE;
         settle_cnt_q   <= '0;
         prev_q         <= 2'b00;
         win_cnt_q      <= '0;
         acc_q          <= 4'd0;
         count_enable_q <= 1'b0;
         direction_q    <= 1'b0;
         error_q        <= 1'b0;
         speed_q        <= 4'd0;
      end else begin
         count_enable_q <= 1'b0;
         error_q        <= 1'b0;

         case (state_q)
            ST_SETTLE: begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  // The resting position becomes the reference, so it can
                  // never be mistaken for a step.
                  prev_q  <= filt;
                  state_q <= ST_TRACK;
               end else begin
                  settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
               end
            end

            ST_TRACK: begin
               prev_q <= filt;

               if (step) begin
                  count_enable_q <= 1'b1;
                  direction_q    <= step_cw;
               end
               error_q <= illegal;

               if (win_last) begin
                  speed_q   <= acc_d;
                  acc_q     <= 4'd0;
                  win_cnt_q <= '0;
               end else begin
                  acc_q     <= acc_d;
                  win_cnt_q <= win_cnt_q + WIN_W'(1);
               end
            end

            default: begin
               state_q <= ST_SETTLE;
            end
         endcase
      end
   end

   assign COUNT_ENABLE = count_enable_q;
   assign DIRECTION    = direction_q;
   assign SPEED        = speed_q;
   assign ERROR        = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_quadrature_decoder
//
// Drives encoder patterns into quadrature_decoder (SYNC_STAGES=2,
// FILTER_CYCLES=4, WINDOW_CYCLES=100). A monitor records every
// COUNT_ENABLE/ERROR event as {ERROR, COUNT_ENABLE, DIRECTION} with the cycle
// it was seen; each test pushes the events it expects and then pops and
// compares them against what was recorded.
// -----------------------------------------------------------------------------
module tb_quadrature_decoder;

   localparam int SYNC_STAGES   = 2;
   localparam int FILTER_CYCLES = 4;
   localparam int WINDOW_CYCLES = 100;
   // Drive at cycle c -> first sample at c+1 -> pulse seen at c+1+S+F.
   localparam int LATENCY       = 1 + SYNC_STAGES + FILTER_CYCLES;

   localparam logic [2:0] EV_CW  = 3'b011;
   localparam logic [2:0] EV_CCW = 3'b010;

   // ---------------------------------------------------------------- clock/reset
   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       ENC_A = 1'b1;
   logic       ENC_B = 1'b1;
   logic       COUNT_ENABLE;
   logic       DIRECTION;
   logic [3:0] SPEED;
   logic       ERROR;

   always #5 CLOCK = ~CLOCK;

   int cyc = 0;
   always @(posedge CLOCK) cyc <= cyc + 1;

   quadrature_decoder #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .WINDOW_CYCLES (WINDOW_CYCLES)
   ) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .ENC_A        (ENC_A),
      .ENC_B        (ENC_B),
      .COUNT_ENABLE (COUNT_ENABLE),
      .DIRECTION    (DIRECTION),
      .SPEED        (SPEED),
      .ERROR        (ERROR)
   );

   // ---------------------------------------------------------------- scoreboard
   logic [2:0] exp_q[$];
   logic [2:0] obs_q[$];
   int         obs_cyc_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   always @(negedge CLOCK) begin
      if (!RESET && (COUNT_ENABLE || ERROR)) begin
         obs_q.push_back({ERROR, COUNT_ENABLE, DIRECTION});
         obs_cyc_q.push_back(cyc);
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic tick(input int n);
      repeat (n) @(negedge CLOCK);
      #1;
   endtask

   task automatic drive_ab(input logic [1:0] ab);
      ENC_A = ab[1];
      ENC_B = ab[0];
   endtask

   task automatic clear_sb();
      exp_q.delete();
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic pop_event(input int t0, output logic [2:0] exp_ev,
                            output logic [2:0] obs_ev, output int lat);
      if (exp_q.size() > 0) exp_ev = exp_q.pop_front();
      else                  exp_ev = 3'bxxx;
      if (obs_q.size() > 0) begin
         obs_ev = obs_q.pop_front();
         lat    = obs_cyc_q.pop_front() - t0;
      end else begin
         obs_ev = 3'b000;
         lat    = -1;
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      logic [2:0] e, o;
      int         lat, t0;
      logic [1:0] walk [2];
      walk = '{2'b10, 2'b00};

      tick(3);
      n_checks++;
      if ({COUNT_ENABLE, DIRECTION, SPEED, ERROR} !== 7'b0)
         $display("FAIL reset_outputs: got %b expected 0000000",
                  {COUNT_ENABLE, DIRECTION, SPEED, ERROR});
      else n_pass++;

      // Encoder resting at 11 through reset must not produce a step.
      RESET = 1'b0;
      tick(50);
      n_checks++;
      if (obs_q.size() != 0)
         $display("FAIL reset_rest_events: got %0d events expected 0", obs_q.size());
      else n_pass++;
      n_checks++;
      if (SPEED !== 4'd0) $display("FAIL reset_rest_speed: got %0d expected 0", SPEED);
      else n_pass++;
      clear_sb();

      // Two clockwise steps bring the encoder to 00: 11 -> 10 -> 00.
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(EV_CW);
         t0 = cyc;
         drive_ab(walk[i]);
         tick(20);
         pop_event(t0, e, o, lat);
         n_checks++;
         if (o !== e) $display("FAIL walk_event %0d: got %b expected %b", i, o, e);
         else n_pass++;
      end
   endtask

   task automatic test_clockwise();
      logic [2:0] e, o;
      int         lat, t0;
      logic [1:0] seq [4];
      seq = '{2'b01, 2'b11, 2'b10, 2'b00};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(EV_CW);
         t0 = cyc;
         drive_ab(seq[i]);
         tick(20);
         n_checks++;
         if (obs_q.size() != 1)
            $display("FAIL cw_pulse_count %0d: got %0d expected 1", i, obs_q.size());
         else n_pass++;
         pop_event(t0, e, o, lat);
         n_checks++;
         if (o !== e) $display("FAIL cw_event %0d: got %b expected %b", i, o, e);
         else n_pass++;
         n_checks++;
         if (lat < LATENCY - 1 || lat > LATENCY + 1)
            $display("FAIL cw_latency %0d: got %0d expected %0d+-1", i, lat, LATENCY);
         else n_pass++;
         clear_sb();
      end
   endtask

   task automatic test_reverse();
      logic [2:0] e, o;
      int         lat, t0;
      logic [1:0] seq [4];
      seq = '{2'b10, 2'b11, 2'b01, 2'b00};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(EV_CCW);
         t0 = cyc;
         drive_ab(seq[i]);
         tick(20);
         pop_event(t0, e, o, lat);
         n_checks++;
         if (o !== e) $display("FAIL ccw_event %0d: got %b expected %b", i, o, e);
         else n_pass++;
         n_checks++;
         if (lat < LATENCY - 1 || lat > LATENCY + 1)
            $display("FAIL ccw_latency %0d: got %0d expected %0d+-1", i, lat, LATENCY);
         else n_pass++;
      end
      tick(20);
      n_checks++;
      if (DIRECTION !== 1'b0) $display("FAIL ccw_dir_hold: got %b expected 0", DIRECTION);
      else n_pass++;
      n_checks++;
      if (obs_q.size() != 0)
         $display("FAIL ccw_extra_events: got %0d expected 0", obs_q.size());
      else n_pass++;
      clear_sb();
   endtask

   task automatic test_glitch();
      logic [2:0] e, o;
      int         lat, t_rise, t_fall;

      // Three cycles is one short of the filter length.
      drive_ab(2'b10);
      tick(FILTER_CYCLES - 1);
      drive_ab(2'b00);
      tick(20);
      n_checks++;
      if (obs_q.size() != 0)
         $display("FAIL glitch_ignored: got %0d events expected 0", obs_q.size());
      else n_pass++;
      clear_sb();

      // A full-length pulse on A: rising A from 00 is a reverse step, the
      // return to 00 a clockwise one.
      exp_q.push_back(EV_CCW);
      exp_q.push_back(EV_CW);
      t_rise = cyc;
      drive_ab(2'b10);
      tick(FILTER_CYCLES);
      t_fall = cyc;
      drive_ab(2'b00);
      tick(20);
      n_checks++;
      if (obs_q.size() != 2)
         $display("FAIL pulse_count: got %0d expected 2", obs_q.size());
      else n_pass++;
      pop_event(t_rise, e, o, lat);
      n_checks++;
      if (o !== e) $display("FAIL pulse_rise_event: got %b expected %b", o, e);
      else n_pass++;
      pop_event(t_fall, e, o, lat);
      n_checks++;
      if (o !== e) $display("FAIL pulse_fall_event: got %b expected %b", o, e);
      else n_pass++;
      n_checks++;
      if (lat < LATENCY - 1 || lat > LATENCY + 1)
         $display("FAIL pulse_fall_latency: got %0d expected %0d+-1", lat, LATENCY);
      else n_pass++;
      clear_sb();
   endtask

   task automatic test_illegal();
      logic [2:0] e, o;
      int         lat, t0;
      // DIRECTION was left at 1 by the last clockwise step and must hold.
      exp_q.push_back(3'b101);
      t0 = cyc;
      drive_ab(2'b11);
      tick(20);
      n_checks++;
      if (obs_q.size() != 1)
         $display("FAIL illegal_count: got %0d events expected 1", obs_q.size());
      else n_pass++;
      pop_event(t0, e, o, lat);
      n_checks++;
      if (o !== e) $display("FAIL illegal_event: got %b expected %b", o, e);
      else n_pass++;
      n_checks++;
      if (DIRECTION !== 1'b1) $display("FAIL illegal_dir_hold: got %b expected 1", DIRECTION);
      else n_pass++;
      clear_sb();
   endtask

   task automatic test_speed();
      logic [2:0] e, o;
      int         lat;
      int         t0s [20];
      logic [1:0] seq [4];
      seq = '{2'b01, 2'b11, 2'b10, 2'b00};

      drive_ab(2'b00);
      RESET = 1'b1;
      tick(2);
      clear_sb();
      RESET = 1'b0;
      // Settle ends on cycle 7 after release; the first window closes on
      // cycle 7 + WINDOW_CYCLES.
      tick(8);
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(EV_CW);
         t0s[i] = cyc;
         drive_ab(seq[i % 4]);
         tick(FILTER_CYCLES);
      end
      tick(18);
      n_checks++;
      if (SPEED !== 4'd0) $display("FAIL speed_before_close: got %0d expected 0", SPEED);
      else n_pass++;
      n_checks++;
      if (obs_q.size() != 20)
         $display("FAIL speed_step_count: got %0d expected 20", obs_q.size());
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         pop_event(t0s[i], e, o, lat);
         n_checks++;
         if (o !== e) $display("FAIL speed_step %0d: got %b expected %b", i, o, e);
         else n_pass++;
      end
      tick(1);
      n_checks++;
      if (SPEED !== 4'd15) $display("FAIL speed_saturated: got %0d expected 15", SPEED);
      else n_pass++;
      tick(WINDOW_CYCLES - 1);
      n_checks++;
      if (SPEED !== 4'd15) $display("FAIL speed_held: got %0d expected 15", SPEED);
      else n_pass++;
      tick(1);
      n_checks++;
      if (SPEED !== 4'd0) $display("FAIL speed_idle: got %0d expected 0", SPEED);
      else n_pass++;
      clear_sb();
   endtask

   task automatic test_reset_mid();
      logic [2:0] e, o;
      int         lat, t0;
      n_checks++;
      if (DIRECTION !== 1'b1) $display("FAIL mid_pre_dir: got %b expected 1", DIRECTION);
      else n_pass++;

      // Start a step, then reset while it is still inside the filter.
      drive_ab(2'b01);
      tick(3);
      RESET = 1'b1;
      #1;
      n_checks++;
      if ({COUNT_ENABLE, DIRECTION, SPEED, ERROR} !== 7'b0)
         $display("FAIL mid_reset_outputs: got %b expected 0000000",
                  {COUNT_ENABLE, DIRECTION, SPEED, ERROR});
      else n_pass++;
      tick(3);
      clear_sb();
      RESET = 1'b0;
      tick(50);
      n_checks++;
      if (obs_q.size() != 0)
         $display("FAIL mid_dropped_step: got %0d events expected 0", obs_q.size());
      else n_pass++;
      clear_sb();

      exp_q.push_back(EV_CW);
      t0 = cyc;
      drive_ab(2'b11);
      tick(20);
      pop_event(t0, e, o, lat);
      n_checks++;
      if (o !== e) $display("FAIL mid_resume_event: got %b expected %b", o, e);
      else n_pass++;
      n_checks++;
      if (lat < LATENCY - 1 || lat > LATENCY + 1)
         $display("FAIL mid_resume_latency: got %0d expected %0d+-1", lat, LATENCY);
      else n_pass++;
      n_checks++;
      if (obs_q.size() != 0)
         $display("FAIL mid_extra_events: got %0d expected 0", obs_q.size());
      else n_pass++;
      clear_sb();
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      test_reset();
      test_clockwise();
      test_reverse();
      test_glitch();
      test_illegal();
      test_speed();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
